// File: rtl/regif_slave.sv
// regif_slave: IPIF-style master-request register slave with an 8-word window.
// Word 0 is a read-only ID, words 1..6 are read/write, word 7 reads live status_in.
module regif_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h4E41_0001
) (
  input  logic         reg_int_clk,
  input  logic         reg_int_reset_n,
  input  logic         IP2Bus_MstRd_Req,
  input  logic         IP2Bus_MstWr_Req,
  input  logic [31:0]  IP2Bus_Mst_Addr,
  input  logic [3:0]   IP2Bus_Mst_BE,
  input  logic         IP2Bus_Mst_Reset,
  input  logic [31:0]  IP2Bus_MstWr_d,
  output logic         Bus2IP_Mst_CmdAck,
  output logic         Bus2IP_Mst_Cmplt,
  output logic         Bus2IP_Mst_Error,
  output logic [31:0]  Bus2IP_MstRd_d,
  output logic         Bus2IP_MstRd_src_rdy_n,
  output logic         Bus2IP_MstWr_dst_rdy_n,
  input  logic [31:0]  status_in,
  output logic [191:0] rw_regs
);

  localparam int unsigned DW   = 32;
  localparam int unsigned BEW  = DW / 8;
  localparam int unsigned NRW  = 6;
  localparam int unsigned IDXW = 3;
  localparam int unsigned RWW  = DW * NRW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    CPL   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:2]     addr_q, addr_d;
  logic [BEW-1:0]    be_q, be_d;
  logic              wr_q, wr_d;
  logic [RWW-1:0]    regs_q, regs_d;
  logic              ack_q, ack_d;
  logic              cmplt_q, cmplt_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdd_q, rdd_d;
  logic              src_rdy_n_q, src_rdy_n_d;
  logic              dst_rdy_n_q, dst_rdy_n_d;

  logic              hit_c;
  logic [IDXW-1:0]   idx_c;
  logic              rw_slot_c;
  logic              err_c;
  logic [DW-1:0]     rd_val_c;
  logic              unused_addr_lsbs;

  // Word-aligned decode: address bits [1:0] carry no meaning here.
  assign unused_addr_lsbs = ^IP2Bus_Mst_Addr[1:0];

  assign hit_c     = (addr_q[DW-1:5] == BASE_ADDR[DW-1:5]);
  assign idx_c     = addr_q[4:2];
  assign rw_slot_c = (idx_c != IDXW'(0)) && (idx_c != IDXW'(7));
  assign err_c     = !hit_c || (wr_q && !rw_slot_c);

  // Read mux for the latched address; zero on a miss.
  always_comb begin
    rd_val_c = '0;
    if (hit_c) begin
      if (idx_c == IDXW'(0)) begin
        rd_val_c = ID_VALUE;
      end else if (idx_c == IDXW'(7)) begin
        rd_val_c = status_in;
      end else begin
        for (int unsigned r = 0; r < NRW; r++) begin
          if (idx_c == IDXW'(r + 1)) rd_val_c = regs_q[r*DW +: DW];
        end
      end
    end
  end

  // Next state plus next values of every registered bus output.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wr_d        = wr_q;
    regs_d      = regs_q;
    ack_d       = 1'b0;
    cmplt_d     = 1'b0;
    err_d       = 1'b0;
    rdd_d       = '0;
    src_rdy_n_d = 1'b1;
    dst_rdy_n_d = 1'b1;

    if (IP2Bus_Mst_Reset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (IP2Bus_MstWr_Req || IP2Bus_MstRd_Req) begin
            addr_d  = IP2Bus_Mst_Addr[DW-1:2];
            be_d    = IP2Bus_Mst_BE;
            wr_d    = IP2Bus_MstWr_Req;
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end
        ACK: begin
          if (wr_q) begin
            state_d     = WDATA;
            dst_rdy_n_d = 1'b0;
          end else begin
            state_d     = RDATA;
            src_rdy_n_d = 1'b0;
            rdd_d       = rd_val_c;
          end
        end
        WDATA: begin
          // Write data is taken at the close of the dst_rdy_n beat.
          if (hit_c) begin
            for (int unsigned r = 0; r < NRW; r++) begin
              for (int unsigned b = 0; b < BEW; b++) begin
                if ((idx_c == IDXW'(r + 1)) && be_q[b]) begin
                  regs_d[r*DW + b*8 +: 8] = IP2Bus_MstWr_d[b*8 +: 8];
                end
              end
            end
          end
          state_d = CPL;
          cmplt_d = 1'b1;
          err_d   = err_c;
        end
        RDATA: begin
          state_d = CPL;
          cmplt_d = 1'b1;
          err_d   = err_c;
        end
        CPL: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge reg_int_clk or negedge reg_int_reset_n) begin
    if (!reg_int_reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wr_q        <= 1'b0;
      regs_q      <= '0;
      ack_q       <= 1'b0;
      cmplt_q     <= 1'b0;
      err_q       <= 1'b0;
      rdd_q       <= '0;
      src_rdy_n_q <= 1'b1;
      dst_rdy_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wr_q        <= wr_d;
      regs_q      <= regs_d;
      ack_q       <= ack_d;
      cmplt_q     <= cmplt_d;
      err_q       <= err_d;
      rdd_q       <= rdd_d;
      src_rdy_n_q <= src_rdy_n_d;
      dst_rdy_n_q <= dst_rdy_n_d;
    end
  end

  assign Bus2IP_Mst_CmdAck      = ack_q;
  assign Bus2IP_Mst_Cmplt       = cmplt_q;
  assign Bus2IP_Mst_Error       = err_q;
  assign Bus2IP_MstRd_d         = rdd_q;
  assign Bus2IP_MstRd_src_rdy_n = src_rdy_n_q;
  assign Bus2IP_MstWr_dst_rdy_n = dst_rdy_n_q;
  assign rw_regs                = regs_q;

endmodule

// File: tb/tb_regif_slave.sv
// Self-checking bench for regif_slave: directed scenarios plus randomized
// transactions against a word-array reference model.
module tb_regif_slave;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam logic [31:0] ID   = 32'h4E41_0001;

  logic         clk, rst_n;
  logic         rd_req, wr_req, mst_rst;
  logic [31:0]  addr, wdata, status;
  logic [3:0]   be;
  logic         cmdack, cmplt, err, src_rdy_n, dst_rdy_n;
  logic [31:0]  rdd;
  logic [191:0] rw;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array of the six read/write words.
  logic [31:0] m_regs [1:6];

  // Observations gathered by run_bus.
  int          n_ack, n_beat, n_cpl, n_stray;
  int          o_ack_k  [2];
  int          o_beat_k [2];
  int          o_cpl_k  [2];
  logic        o_beat_rd[2];
  logic [31:0] o_beat_d [2];
  logic        o_cpl_err[2];

  regif_slave #(.BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
    .reg_int_clk            (clk),
    .reg_int_reset_n        (rst_n),
    .IP2Bus_MstRd_Req       (rd_req),
    .IP2Bus_MstWr_Req       (wr_req),
    .IP2Bus_Mst_Addr        (addr),
    .IP2Bus_Mst_BE          (be),
    .IP2Bus_Mst_Reset       (mst_rst),
    .IP2Bus_MstWr_d         (wdata),
    .Bus2IP_Mst_CmdAck      (cmdack),
    .Bus2IP_Mst_Cmplt       (cmplt),
    .Bus2IP_Mst_Error       (err),
    .Bus2IP_MstRd_d         (rdd),
    .Bus2IP_MstRd_src_rdy_n (src_rdy_n),
    .Bus2IP_MstWr_dst_rdy_n (dst_rdy_n),
    .status_in              (status),
    .rw_regs                (rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [191:0] m_rw();
    return {m_regs[6], m_regs[5], m_regs[4], m_regs[3], m_regs[2], m_regs[1]};
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] b);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (b[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int idx;
    idx = int'(a[4:2]);
    if (a[31:5] == BASE[31:5] && idx >= 1 && idx <= 6)
      m_regs[idx] = (m_regs[idx] & ~be_mask(b)) | (d & be_mask(b));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [31:0] st);
    int idx;
    idx = int'(a[4:2]);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    if (idx == 0) return ID;
    if (idx == 7) return st;
    return m_regs[idx];
  endfunction

  function automatic logic m_err(input logic is_wr, input logic [31:0] a);
    int idx;
    idx = int'(a[4:2]);
    if (a[31:5] != BASE[31:5]) return 1'b1;
    return is_wr && (idx == 0 || idx == 7);
  endfunction

  // Master driver: asserts requests at k=0 and records what happens over ncyc cycles.
  // On each CmdAck it drops the write request if present, else the read request.
  task automatic run_bus(input logic do_wr, input logic do_rd, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, input int ncyc);
    n_ack = 0; n_beat = 0; n_cpl = 0; n_stray = 0;
    for (int i = 0; i < 2; i++) begin
      o_ack_k[i] = -1; o_beat_k[i] = -1; o_cpl_k[i] = -1;
      o_beat_rd[i] = 1'b0; o_beat_d[i] = 32'h0; o_cpl_err[i] = 1'b0;
    end
    addr = a; be = b; wdata = d; wr_req = do_wr; rd_req = do_rd;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (cmdack) begin
        if (n_ack < 2) o_ack_k[n_ack] = k;
        n_ack++;
      end
      if (!src_rdy_n || !dst_rdy_n) begin
        if (n_beat < 2) begin
          o_beat_k[n_beat] = k; o_beat_rd[n_beat] = !src_rdy_n; o_beat_d[n_beat] = rdd;
        end
        n_beat++;
      end
      if (src_rdy_n && rdd !== 32'h0) n_stray++;
      if (cmplt) begin
        if (n_cpl < 2) begin o_cpl_k[n_cpl] = k; o_cpl_err[n_cpl] = err; end
        n_cpl++;
      end
      if (cmdack) begin
        if (wr_req) wr_req = 1'b0;
        else rd_req = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_req = 0; wr_req = 0; mst_rst = 0;
    addr = 0; be = 0; wdata = 0; status = 32'hC0DE_0000;
    for (int i = 1; i <= 6; i++) m_regs[i] = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmdack, cmplt, err, src_rdy_n, dst_rdy_n} !== 5'b00011 || rdd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack/cpl/err/src_n/dst_n=%b rd_d=%h, want 00011 rd_d=0",
               {cmdack, cmplt, err, src_rdy_n, dst_rdy_n}, rdd);
    end
    n_checks++;
    if (rw !== 192'h0) begin
      n_fail++; $display("FAIL reset_rw_regs: got %h want 0", rw);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_basic();
    logic [31:0] exp_rd;
    run_bus(1'b1, 1'b0, BASE + 32'h04, 4'hF, 32'h1234_5678, 6);
    m_write(BASE + 32'h04, 4'hF, 32'h1234_5678);
    n_checks++;
    if (n_ack !== 1 || o_ack_k[0] !== 1 || n_beat !== 1 || o_beat_k[0] !== 2 || o_beat_rd[0] !== 1'b0
        || n_cpl !== 1 || o_cpl_k[0] !== 3) begin
      n_fail++;
      $display("FAIL wr_timing: ack n=%0d k=%0d beat n=%0d k=%0d rd=%b cpl n=%0d k=%0d, want 1/1 1/2 wr 1/3",
               n_ack, o_ack_k[0], n_beat, o_beat_k[0], o_beat_rd[0], n_cpl, o_cpl_k[0]);
    end
    n_checks++;
    if (o_cpl_err[0] !== 1'b0 || rw[31:0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wr_full: err=%b reg1=%h want err=0 reg1=12345678", o_cpl_err[0], rw[31:0]);
    end
    run_bus(1'b1, 1'b0, BASE + 32'h04, 4'b0101, 32'hAAAA_AAAA, 6);
    m_write(BASE + 32'h04, 4'b0101, 32'hAAAA_AAAA);
    n_checks++;
    if (rw[31:0] !== 32'h12AA_56AA || rw !== m_rw()) begin
      n_fail++; $display("FAIL wr_be0101: reg1=%h want 12aa56aa", rw[31:0]);
    end
    exp_rd = m_read(BASE + 32'h04, status);
    run_bus(1'b0, 1'b1, BASE + 32'h04, 4'h0, 32'h0, 6);
    n_checks++;
    if (n_beat !== 1 || o_beat_k[0] !== 2 || o_beat_rd[0] !== 1'b1 || o_beat_d[0] !== exp_rd
        || o_cpl_k[0] !== 3 || o_cpl_err[0] !== 1'b0 || n_stray !== 0) begin
      n_fail++;
      $display("FAIL rd_reg1: beat k=%0d rd=%b d=%h cpl k=%0d err=%b stray=%0d, want k=2 rd=1 d=%h cpl 3 err 0",
               o_beat_k[0], o_beat_rd[0], o_beat_d[0], o_cpl_k[0], o_cpl_err[0], n_stray, exp_rd);
    end
  endtask

  task automatic test_id_and_ro();
    run_bus(1'b0, 1'b1, BASE + 32'h00, 4'h0, 32'h0, 6);
    n_checks++;
    if (o_beat_d[0] !== ID || o_cpl_err[0] !== 1'b0) begin
      n_fail++; $display("FAIL rd_id: got %h err=%b want %h err=0", o_beat_d[0], o_cpl_err[0], ID);
    end
    status = 32'h5A5A_0F0F;
    run_bus(1'b0, 1'b1, BASE + 32'h1C, 4'h0, 32'h0, 6);
    n_checks++;
    if (o_beat_d[0] !== 32'h5A5A_0F0F || o_cpl_err[0] !== 1'b0) begin
      n_fail++; $display("FAIL rd_status: got %h err=%b want 5a5a0f0f err=0", o_beat_d[0], o_cpl_err[0]);
    end
    run_bus(1'b1, 1'b0, BASE + 32'h1C, 4'hF, 32'hDEAD_BEEF, 6);
    n_checks++;
    if (n_cpl !== 1 || o_cpl_err[0] !== 1'b1 || rw !== m_rw()) begin
      n_fail++; $display("FAIL wr_idx7: cpl=%0d err=%b rw=%h want err=1 rw=%h", n_cpl, o_cpl_err[0], rw, m_rw());
    end
    run_bus(1'b1, 1'b0, BASE + 32'h00, 4'hF, 32'hDEAD_BEEF, 6);
    n_checks++;
    if (o_cpl_err[0] !== 1'b1 || rw !== m_rw()) begin
      n_fail++; $display("FAIL wr_idx0: err=%b rw=%h want err=1 rw=%h", o_cpl_err[0], rw, m_rw());
    end
  endtask

  task automatic test_miss();
    run_bus(1'b0, 1'b1, BASE + 32'h20, 4'h0, 32'h0, 6);
    n_checks++;
    if (o_beat_d[0] !== 32'h0 || n_cpl !== 1 || o_cpl_err[0] !== 1'b1 || n_stray !== 0) begin
      n_fail++; $display("FAIL rd_miss: d=%h cpl=%0d err=%b want d=0 cpl=1 err=1", o_beat_d[0], n_cpl, o_cpl_err[0]);
    end
    run_bus(1'b1, 1'b0, BASE + 32'h24, 4'hF, 32'hFFFF_FFFF, 6);
    n_checks++;
    if (o_cpl_err[0] !== 1'b1 || rw !== m_rw()) begin
      n_fail++; $display("FAIL wr_miss: err=%b rw=%h want err=1 rw=%h", o_cpl_err[0], rw, m_rw());
    end
    run_bus(1'b1, 1'b0, BASE + 32'h08, 4'h0, 32'hFFFF_FFFF, 6);
    n_checks++;
    if (n_cpl !== 1 || o_cpl_err[0] !== 1'b0 || rw !== m_rw()) begin
      n_fail++; $display("FAIL wr_be0: cpl=%0d err=%b rw=%h want err=0 rw=%h", n_cpl, o_cpl_err[0], rw, m_rw());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    m_write(BASE + 32'h0C, 4'hF, d);
    run_bus(1'b1, 1'b1, BASE + 32'h0C, 4'hF, d, 10);
    n_checks++;
    if (n_ack !== 2 || o_ack_k[0] !== 1 || o_ack_k[1] !== 5) begin
      n_fail++; $display("FAIL b2b_ack: n=%0d k0=%0d k1=%0d want 2/1/5", n_ack, o_ack_k[0], o_ack_k[1]);
    end
    n_checks++;
    if (o_beat_rd[0] !== 1'b0 || o_beat_k[0] !== 2 || o_beat_rd[1] !== 1'b1 || o_beat_k[1] !== 6
        || o_beat_d[1] !== d) begin
      n_fail++;
      $display("FAIL b2b_beats: b0 rd=%b k=%0d b1 rd=%b k=%0d d=%h want wr@2 rd@6 d=%h",
               o_beat_rd[0], o_beat_k[0], o_beat_rd[1], o_beat_k[1], o_beat_d[1], d);
    end
    n_checks++;
    if (n_cpl !== 2 || o_cpl_k[0] !== 3 || o_cpl_k[1] !== 7 || o_cpl_err[0] !== 1'b0 || o_cpl_err[1] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_cpl: n=%0d k0=%0d k1=%0d want 2/3/7 no error", n_cpl, o_cpl_k[0], o_cpl_k[1]);
    end
  endtask

  task automatic test_mst_reset();
    int bad;
    bad = 0;
    addr = BASE + 32'h08; be = 4'hF; wdata = ~m_regs[2]; wr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (cmdack !== 1'b1) begin
      n_fail++; $display("FAIL mrst_ack: got %b want 1", cmdack);
    end
    wr_req = 1'b0; mst_rst = 1'b1;
    @(negedge clk);
    mst_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!dst_rdy_n || cmplt || cmdack) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0 || rw !== m_rw()) begin
      n_fail++; $display("FAIL mrst_abort: bad cycles=%0d rw=%h want 0 rw=%h", bad, rw, m_rw());
    end
    @(posedge clk); #1;
    run_bus(1'b0, 1'b1, BASE + 32'h08, 4'h0, 32'h0, 6);
    n_checks++;
    if (o_ack_k[0] !== 1 || o_beat_d[0] !== m_regs[2]) begin
      n_fail++; $display("FAIL mrst_resume: ack k=%0d d=%h want 1 d=%h", o_ack_k[0], o_beat_d[0], m_regs[2]);
    end
  endtask

  task automatic test_reset_mid_read();
    int bad;
    bad = 0;
    addr = BASE + 32'h0C; rd_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    for (int i = 1; i <= 6; i++) m_regs[i] = 32'h0;
    n_checks++;
    if ({cmdack, cmplt, err, src_rdy_n, dst_rdy_n} !== 5'b00011 || rdd !== 32'h0 || rw !== 192'h0) begin
      n_fail++;
      $display("FAIL rst_mid_read: ack/cpl/err/src_n/dst_n=%b rd_d=%h rw=%h want 00011 0 0",
               {cmdack, cmplt, err, src_rdy_n, dst_rdy_n}, rdd, rw);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cmplt || cmdack) bad++;
    end
    @(posedge clk); #1;
    run_bus(1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'h0BAD_F00D, 6);
    m_write(BASE + 32'h14, 4'hF, 32'h0BAD_F00D);
    n_checks++;
    if (bad !== 0 || o_ack_k[0] !== 1 || o_cpl_k[0] !== 3 || rw !== m_rw()) begin
      n_fail++;
      $display("FAIL rst_resume: stray=%0d ack k=%0d cpl k=%0d rw=%h want 0/1/3 rw=%h",
               bad, o_ack_k[0], o_cpl_k[0], rw, m_rw());
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_rd;
    logic [3:0]  b;
    logic        is_wr, exp_err;
    for (int i = 0; i < 60; i++) begin
      a = BASE | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 6) == 0) a = a ^ (32'h20 << $urandom_range(0, 26));
      is_wr  = 1'($urandom_range(0, 1));
      b      = 4'($urandom_range(0, 15));
      d      = $urandom;
      status = $urandom;
      exp_err = m_err(is_wr, a);
      exp_rd  = m_read(a, status);
      run_bus(is_wr, !is_wr, a, b, d, 6);
      if (is_wr) m_write(a, b, d);
      n_checks++;
      if (n_ack !== 1 || o_ack_k[0] !== 1 || n_beat !== 1 || o_beat_k[0] !== 2 || o_beat_rd[0] !== !is_wr
          || n_cpl !== 1 || o_cpl_k[0] !== 3 || o_cpl_err[0] !== exp_err || n_stray !== 0) begin
        n_fail++;
        $display("FAIL rnd%0d_handshake: a=%h wr=%b ack %0d@%0d beat %0d@%0d rd=%b cpl %0d@%0d err=%b stray=%0d want err=%b",
                 i, a, is_wr, n_ack, o_ack_k[0], n_beat, o_beat_k[0], o_beat_rd[0], n_cpl, o_cpl_k[0],
                 o_cpl_err[0], n_stray, exp_err);
      end
      if (!is_wr) begin
        n_checks++;
        if (o_beat_d[0] !== exp_rd) begin
          n_fail++; $display("FAIL rnd%0d_rdata: a=%h got %h want %h", i, a, o_beat_d[0], exp_rd);
        end
      end
      n_checks++;
      if (rw !== m_rw()) begin
        n_fail++; $display("FAIL rnd%0d_regs: a=%h be=%h got %h want %h", i, a, b, rw, m_rw());
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_id_and_ro();
    test_miss();
    test_back_to_back();
    test_mst_reset();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
